// File: rtl/uart_frame_parser_if.sv
// Receive-side byte stream feeding the frame parser: one byte per rx_vld strobe.
interface uart_frame_parser_if;
    logic [7:0] rx_data;
    logic       rx_vld;

    modport master (output rx_data, output rx_vld);
    modport slave  (input  rx_data, input  rx_vld);
endinterface

// File: rtl/uart_frame_parser.sv
// Frame parser for HEAD0 HEAD1 TYPE payload[2*N_FIELDS] SUM byte streams.
// The payload is collected in a shadow buffer and published to field_data
// only after the checksum matches. An inter-byte gap watchdog aborts stalled frames.
module uart_frame_parser #(
    parameter int unsigned N_FIELDS    = 4,
    parameter logic [7:0]  HEAD0       = 8'hFF,
    parameter logic [7:0]  HEAD1       = 8'hAA,
    parameter logic [7:0]  FRAME_TYPE  = 8'h51,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cnt_clr,
    uart_frame_parser_if.slave        rx,
    output logic [N_FIELDS*16-1:0]    field_data,
    output logic                      frame_upd,
    output logic                      busy,
    output logic [31:0]               good_cnt,
    output logic [31:0]               sum_err_cnt,
    output logic [31:0]               tout_err_cnt
);

    localparam int unsigned NB = 2 * N_FIELDS;
    localparam int unsigned IW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned GW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned DW = N_FIELDS * 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR1,
        S_TYPE,
        S_PAYLOAD,
        S_CHKSUM
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [7:0]      acc_q, acc_d;
    logic [GW-1:0]   gap_q, gap_d;
    logic [DW-1:0]   shadow_q, shadow_d;
    logic [DW-1:0]   field_q, field_d;
    logic            upd_q, upd_d;
    logic            busy_q, busy_d;
    logic [31:0]     good_q, good_d;
    logic [31:0]     sum_err_q, sum_err_d;
    logic [31:0]     tout_q, tout_d;
    logic            good_inc, sum_inc, tout_inc;

    // Saturating increment; clear wins over a same-cycle increment.
    function automatic logic [31:0] cnt_next(input logic [31:0] v, input logic inc,
                                             input logic clr);
        if (clr)
            return 32'd0;
        else if (inc && (v != 32'hFFFF_FFFF))
            return v + 32'd1;
        else
            return v;
    endfunction

    // Next-state, datapath and watchdog decisions for one clock.
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        gap_d    = gap_q;
        shadow_d = shadow_q;
        field_d  = field_q;
        upd_d    = 1'b0;
        good_inc = 1'b0;
        sum_inc  = 1'b0;
        tout_inc = 1'b0;

        if (rx.rx_vld) begin
            // A byte always resets the gap watchdog, even on the timeout cycle.
            gap_d = '0;
            case (state_q)
                S_IDLE: begin
                    if (rx.rx_data == HEAD0) state_d = S_HDR1;
                end
                S_HDR1: begin
                    if (rx.rx_data == HEAD1)      state_d = S_TYPE;
                    else if (rx.rx_data != HEAD0) state_d = S_IDLE;
                end
                S_TYPE: begin
                    if (rx.rx_data == FRAME_TYPE) begin
                        state_d = S_PAYLOAD;
                        acc_d   = rx.rx_data;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_PAYLOAD: begin
                    shadow_d[{idx_q, 3'b000} +: 8] = rx.rx_data;
                    acc_d = acc_q + rx.rx_data;
                    idx_d = idx_q + IW'(1);
                    if (idx_q == IW'(NB - 1)) state_d = S_CHKSUM;
                end
                S_CHKSUM: begin
                    if (rx.rx_data == acc_q) begin
                        field_d  = shadow_q;
                        upd_d    = 1'b1;
                        good_inc = 1'b1;
                    end else begin
                        sum_inc  = 1'b1;
                    end
                    state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (gap_q == GW'(TIMEOUT_CYC - 1)) begin
                state_d  = S_IDLE;
                gap_d    = '0;
                tout_inc = 1'b1;
            end else begin
                gap_d = gap_q + GW'(1);
            end
        end

        busy_d    = (state_d != S_IDLE);
        good_d    = cnt_next(good_q, good_inc, cnt_clr);
        sum_err_d = cnt_next(sum_err_q, sum_inc, cnt_clr);
        tout_d    = cnt_next(tout_q, tout_inc, cnt_clr);
    end

    // Parser FSM and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            acc_q     <= '0;
            gap_q     <= '0;
            shadow_q  <= '0;
            field_q   <= '0;
            upd_q     <= 1'b0;
            busy_q    <= 1'b0;
            good_q    <= '0;
            sum_err_q <= '0;
            tout_q    <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            gap_q     <= gap_d;
            shadow_q  <= shadow_d;
            field_q   <= field_d;
            upd_q     <= upd_d;
            busy_q    <= busy_d;
            good_q    <= good_d;
            sum_err_q <= sum_err_d;
            tout_q    <= tout_d;
        end
    end

    assign field_data   = field_q;
    assign frame_upd    = upd_q;
    assign busy         = busy_q;
    assign good_cnt     = good_q;
    assign sum_err_cnt  = sum_err_q;
    assign tout_err_cnt = tout_q;

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed plus randomized frames against a frame-level expectation model.
module tb_uart_frame_parser;

    localparam int NF  = 4;
    localparam int TOC = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cnt_clr = 1'b0;
    logic [NF*16-1:0] field_data;
    logic          frame_upd, busy;
    logic [31:0]   good_cnt, sum_err_cnt, tout_err_cnt;

    uart_frame_parser_if rx_if ();

    uart_frame_parser #(.N_FIELDS(NF), .TIMEOUT_CYC(TOC)) dut (
        .clk          (clk),
        .rst          (rst),
        .cnt_clr      (cnt_clr),
        .rx           (rx_if),
        .field_data   (field_data),
        .frame_upd    (frame_upd),
        .busy         (busy),
        .good_cnt     (good_cnt),
        .sum_err_cnt  (sum_err_cnt),
        .tout_err_cnt (tout_err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    // Frame-level expectations.
    logic [63:0] exp_field = '0;
    int exp_good = 0, exp_sum = 0, exp_tout = 0, exp_upd = 0;
    int upd_seen = 0;

    always @(negedge clk) if (frame_upd === 1'b1) upd_seen++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "/field"}, field_data, exp_field);
        chk({tag, "/good"}, good_cnt, 64'(exp_good));
        chk({tag, "/sum_err"}, sum_err_cnt, 64'(exp_sum));
        chk({tag, "/tout"}, tout_err_cnt, 64'(exp_tout));
        chk({tag, "/busy"}, busy, 0);
    endtask

    // One byte strobe; returns at the falling edge after it was sampled.
    task automatic send_byte(input logic [7:0] b, input logic clr = 1'b0);
        rx_if.rx_data = b;
        rx_if.rx_vld  = 1'b1;
        cnt_clr       = clr;
        @(negedge clk);
        rx_if.rx_vld  = 1'b0;
        cnt_clr       = 1'b0;
    endtask

    // Whole frame built from field values; sum_delta corrupts the checksum.
    task automatic send_frame(input logic [63:0] f, input logic [7:0] typ,
                              input logic [7:0] sum_delta, input int max_gap,
                              input logic clr_on_sum = 1'b0);
        logic [7:0] s;
        s = typ;
        send_byte(8'hFF); repeat ($urandom_range(0, max_gap)) @(negedge clk);
        send_byte(8'hAA); repeat ($urandom_range(0, max_gap)) @(negedge clk);
        send_byte(typ);   repeat ($urandom_range(0, max_gap)) @(negedge clk);
        if (typ != 8'h51) return;
        for (int i = 0; i < 2 * NF; i++) begin
            s = s + f[i*8 +: 8];
            send_byte(f[i*8 +: 8]);
            repeat ($urandom_range(0, max_gap)) @(negedge clk);
        end
        send_byte(s + sum_delta, clr_on_sum);
        if (clr_on_sum) begin
            exp_good = 0; exp_sum = 0; exp_tout = 0;
        end else if (sum_delta == 8'h00) begin
            exp_field = f; exp_good++; exp_upd++;
        end else begin
            exp_sum++;
        end
        chk("upd_after_sum", frame_upd, (sum_delta == 8'h00 && !clr_on_sum) ? 1 : 0);
    endtask

    logic [7:0] f34 [12];
    logic [63:0] rf;
    int kind;

    initial begin
        rx_if.rx_data = '0;
        rx_if.rx_vld  = 1'b0;
        f34 = '{8'hFF, 8'hAA, 8'h51, 8'h01, 8'h00, 8'h02, 8'h00,
                8'h03, 8'h00, 8'h04, 8'h00, 8'h5B};

        // Reset state.
        repeat (3) @(negedge clk);
        chk_all("reset");
        chk("reset/upd", frame_upd, 0);
        rst = 1'b0;
        @(negedge clk);

        // Literal good frame: one-cycle pulse right after SUM.
        foreach (f34[i]) send_byte(f34[i]);
        chk("f34/upd", frame_upd, 1);
        exp_field = 64'h0004_0003_0002_0001; exp_good = 1; exp_upd = 1;
        @(negedge clk);
        chk("f34/upd_low", frame_upd, 0);
        chk_all("f34");

        // Same frame, SUM=5C.
        f34[11] = 8'h5C;
        foreach (f34[i]) send_byte(f34[i]);
        chk("f35/upd", frame_upd, 0);
        exp_sum = 1;
        @(negedge clk);
        chk_all("f35");

        // cnt_clr level clears counters, leaves field_data.
        cnt_clr = 1'b1; @(negedge clk); cnt_clr = 1'b0;
        exp_good = 0; exp_sum = 0;
        chk_all("clr");

        // Timeout exactly TOC idle cycles after the last byte.
        send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h51); send_byte(8'h01);
        repeat (TOC - 1) @(negedge clk);
        chk("tout/busy_before", busy, 1);
        chk("tout/cnt_before", tout_err_cnt, 0);
        @(negedge clk);
        exp_tout = 1;
        chk_all("tout");
        send_frame(64'h1234_5678_9ABC_DEF0, 8'h51, 8'h00, 0);
        chk_all("after_tout");

        // Byte arriving on the timeout cycle is taken, no timeout.
        send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h51);
        repeat (TOC - 1) @(negedge clk);
        rf = 64'h0A0B_0C0D_0E0F_1011;
        begin
            logic [7:0] s;
            s = 8'h51;
            for (int i = 0; i < 8; i++) begin s = s + rf[i*8 +: 8]; send_byte(rf[i*8 +: 8]); end
            send_byte(s);
        end
        exp_field = rf; exp_good++; exp_upd++;
        chk("coincide/upd", frame_upd, 1);
        chk_all("coincide");

        // Resync on doubled HEAD0, then a wrong type is ignored.
        send_byte(8'hFF);
        send_frame(64'h00FF_FF00_55AA_0102, 8'h51, 8'h00, 1);
        chk_all("resync");
        send_frame(64'h0, 8'h52, 8'h00, 1);
        chk_all("bad_type");

        // Clear on the mismatching SUM cycle beats the increment.
        send_frame(64'h1111_2222_3333_4444, 8'h51, 8'h01, 0, 1'b1);
        chk_all("clr_vs_err");

        // Reset mid-frame, then one good frame.
        send_byte(8'hFF); send_byte(8'hAA); send_byte(8'h51);
        send_byte(8'h01); send_byte(8'h00); send_byte(8'h02);
        rst = 1'b1; @(negedge clk); @(negedge clk); rst = 1'b0;
        exp_field = '0; exp_good = 0; exp_sum = 0; exp_tout = 0;
        chk_all("mid_rst");
        send_frame(64'h0004_0003_0002_0001, 8'h51, 8'h00, 0);
        chk_all("post_rst");

        // Randomized frames with garbage between them and random gaps.
        for (int n = 0; n < 40; n++) begin
            repeat ($urandom_range(0, 3)) send_byte(8'($urandom_range(0, 254)));
            rf   = {$urandom, $urandom};
            kind = $urandom_range(0, 9);
            if (kind < 6)
                send_frame(rf, 8'h51, 8'h00, 3);
            else if (kind < 8)
                send_frame(rf, 8'h51, 8'($urandom_range(1, 255)), 3);
            else
                send_frame(rf, 8'($urandom_range(0, 255)) | 8'h01 ^ 8'h51 ? 8'h52 : 8'h50, 8'h00, 3);
            @(negedge clk);
            chk_all("rand");
        end

        chk("upd_pulses", upd_seen, exp_upd);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
